// File: rtl/multi_mode_counter_pkg.sv
// Shared definitions for the multi-mode counter: mode encodings, one-shot FSM
// state type and default sizes.
package multi_mode_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_PRESC_W = 4;

    // Counting mode; the reserved code behaves exactly like WRAP.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // One-shot controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } os_state_e;

endpackage

// File: rtl/multi_mode_counter_if.sv
// Control/status bundle of the multi-mode counter.
//   master: drives en, mode, dir, limit, presc_div, load, load_val, start;
//           observes count, tc, busy, done.
//   slave : the counter itself (mirror image of master).
interface multi_mode_counter_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
) ();
    import multi_mode_counter_pkg::*;

    logic               en;
    mode_e              mode;
    logic               dir;
    logic [WIDTH-1:0]   limit;
    logic [PRESC_W-1:0] presc_div;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               start;
    logic [WIDTH-1:0]   count;
    logic               tc;
    logic               busy;
    logic               done;

    modport master (
        output en, mode, dir, limit, presc_div, load, load_val, start,
        input  count, tc, busy, done
    );

    modport slave (
        input  en, mode, dir, limit, presc_div, load, load_val, start,
        output count, tc, busy, done
    );

endinterface

// File: rtl/counter_prescaler.sv
// Enable divider: tick fires on one of every div+1 enabled cycles.
//   clk, rst : clock, synchronous active-high reset
//   en       : advance the phase counter; low freezes it
//   clr      : restart the phase at 0 (load / one-shot arm)
//   div      : divide field, tick period is div+1 enabled cycles
//   tick     : combinational step strobe for the current cycle
module counter_prescaler #(
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] p_q;

    assign tick = en & (p_q == div);

    // Phase counter; a phase above a freshly lowered div restarts silently.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            p_q <= '0;
        end else if (en) begin
            if (p_q >= div) begin
                p_q <= '0;
            end else begin
                p_q <= p_q + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down counter with WRAP, SATURATE and ONESHOT modes, prescaled stepping,
// synchronous load and a terminal-count pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of multi_mode_counter_if
//              in : en, mode, dir, limit, presc_div, load, load_val, start
//              out: count, tc (one-cycle pulse), busy (RUN), done (DONE)
module multi_mode_counter
    import multi_mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned PRESC_W = DEFAULT_PRESC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_mode_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    os_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;
    logic             step_c;
    logic             presc_clr_c;

    logic             is_oneshot_c;
    logic [WIDTH-1:0] wrap_val_c;
    logic             wrap_tc_c;
    logic [WIDTH-1:0] sat_val_c;
    logic [WIDTH-1:0] sat_target_c;
    logic             sat_hit_c;
    logic             sat_moved_c;

    counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (presc_clr_c),
        .div  (bus.presc_div),
        .tick (step_c)
    );

    assign is_oneshot_c = (bus.mode == MODE_ONESHOT);

    // Candidate next values for a wrapping step.
    always_comb begin
        wrap_val_c = count_q;
        wrap_tc_c  = 1'b0;
        if (bus.dir) begin
            if (count_q >= bus.limit) begin
                wrap_val_c = '0;
                wrap_tc_c  = 1'b1;
            end else begin
                wrap_val_c = count_q + ONE;
            end
        end else begin
            if (count_q == '0) begin
                wrap_val_c = bus.limit;
                wrap_tc_c  = 1'b1;
            end else begin
                wrap_val_c = count_q - ONE;
            end
        end
    end

    // Candidate next value for a saturating step; sat_hit_c means the result
    // sits on the bound, sat_moved_c separates reaching it from holding at it.
    always_comb begin
        sat_val_c    = count_q;
        sat_target_c = '0;
        if (bus.dir) begin
            sat_target_c = bus.limit;
            sat_val_c    = (count_q >= bus.limit) ? bus.limit : count_q + ONE;
        end else begin
            sat_val_c    = (count_q == '0) ? '0 : count_q - ONE;
        end
        sat_hit_c   = (sat_val_c == sat_target_c);
        sat_moved_c = (sat_val_c != count_q);
    end

    // Next state / next count; priority is load > start > step.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tc_d        = 1'b0;
        presc_clr_c = 1'b0;

        if (bus.load) begin
            count_d     = bus.load_val;
            presc_clr_c = 1'b1;
        end else if (is_oneshot_c && bus.start) begin
            // Arm, re-arm from DONE, or restart an active run.
            count_d     = bus.dir ? '0 : bus.limit;
            presc_clr_c = 1'b1;
            state_d     = ST_RUN;
        end else if (step_c) begin
            case (bus.mode)
                MODE_SAT: begin
                    count_d = sat_val_c;
                    tc_d    = sat_hit_c & sat_moved_c;
                end
                MODE_ONESHOT: begin
                    // Bound check is on the result so limit=0 finishes on
                    // the first step.
                    if (state_q == ST_RUN) begin
                        count_d = sat_val_c;
                        if (sat_hit_c) begin
                            tc_d    = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    count_d = wrap_val_c;
                    tc_d    = wrap_tc_c;
                end
            endcase
        end

        if (!is_oneshot_c) begin
            state_d = ST_IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed bench for multi_mode_counter.
module tb_multi_mode_counter;
    import multi_mode_counter_pkg::*;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned PRESC_W = 4;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    multi_mode_counter_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

    multi_mode_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int tc_e,
                           input int busy_e, input int done_e);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".tc"},    32'(bus.tc),    32'(tc_e));
        chk({tag, ".busy"},  32'(bus.busy),  32'(busy_e));
        chk({tag, ".done"},  32'(bus.done),  32'(done_e));
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.mode      = MODE_WRAP;
        bus.dir       = 1'b1;
        bus.limit     = 8'd255;
        bus.presc_div = 4'd0;
        bus.load      = 1'b0;
        bus.load_val  = 8'd0;
        bus.start     = 1'b0;
        cyc(2);
        chk_all("reset", 0, 0, 0, 0);

        // WRAP up, limit 5, every cycle
        rst       = 1'b0;
        bus.limit = 8'd5;
        bus.en    = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            chk($sformatf("wrap_k%0d.count", k), 32'(bus.count), 32'(k % 6));
            chk($sformatf("wrap_k%0d.tc", k), 32'(bus.tc), (k % 6 == 0) ? 32'd1 : 32'd0);
        end

        // en freeze mid-WRAP at 7 with presc_div 3, phase preserved
        bus.limit     = 8'd20;
        bus.presc_div = 4'd3;
        bus.load      = 1'b1;
        bus.load_val  = 8'd7;
        cyc(1);
        bus.load = 1'b0;
        chk("frz_load.count", 32'(bus.count), 32'd7);
        cyc(2);
        bus.en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk($sformatf("frz_k%0d.count", k), 32'(bus.count), 32'd7);
        end
        bus.en = 1'b1;
        cyc(1);
        chk("frz_resume1.count", 32'(bus.count), 32'd7);
        cyc(1);
        chk("frz_resume2.count", 32'(bus.count), 32'd8);
        chk("frz_resume2.tc", 32'(bus.tc), 32'd0);

        // SATURATE down from 3, presc_div 2
        bus.mode      = MODE_SAT;
        bus.dir       = 1'b0;
        bus.presc_div = 4'd2;
        bus.load      = 1'b1;
        bus.load_val  = 8'd3;
        cyc(1);
        bus.load = 1'b0;
        chk("sat_load.count", 32'(bus.count), 32'd3);
        for (int k = 1; k <= 15; k++) begin
            cyc(1);
            chk($sformatf("sat_k%0d.count", k), 32'(bus.count),
                (k / 3 >= 3) ? 32'd0 : 32'(3 - k / 3));
            chk($sformatf("sat_k%0d.tc", k), 32'(bus.tc), (k == 9) ? 32'd1 : 32'd0);
        end

        // ONESHOT: load wins over start in IDLE, then steps ignored in IDLE
        bus.mode      = MODE_ONESHOT;
        bus.dir       = 1'b1;
        bus.limit     = 8'd4;
        bus.presc_div = 4'd0;
        bus.load      = 1'b1;
        bus.load_val  = 8'd9;
        bus.start     = 1'b1;
        cyc(1);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        chk_all("ld_vs_start", 9, 0, 0, 0);
        cyc(1);
        chk_all("idle_hold", 9, 0, 0, 0);

        // ONESHOT up to 4, then re-arm
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk_all("os_arm", 0, 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            chk_all($sformatf("os_run%0d", k), k, 0, 1, 0);
        end
        cyc(1);
        chk_all("os_hit", 4, 1, 0, 1);
        cyc(1);
        chk_all("os_held", 4, 0, 0, 1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk_all("os_rearm", 0, 0, 1, 0);
        cyc(2);
        chk_all("os_at2", 2, 0, 1, 0);

        // reset mid-run
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_all("rst_run", 0, 0, 0, 0);
        cyc(1);
        chk_all("rst_after", 0, 0, 0, 0);

        // ONESHOT with limit 0 finishes on the first step
        bus.limit = 8'd0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk_all("os0_arm", 0, 0, 1, 0);
        cyc(1);
        chk_all("os0_done", 0, 1, 0, 1);

        // ONESHOT down from 3
        bus.limit = 8'd3;
        bus.dir   = 1'b0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk_all("osd_arm", 3, 0, 1, 0);
        cyc(2);
        chk_all("osd_at1", 1, 0, 1, 0);
        cyc(1);
        chk_all("osd_done", 0, 1, 0, 1);

        // default configuration behaves as a free-running 8-bit counter
        bus.mode     = MODE_WRAP;
        bus.dir      = 1'b1;
        bus.limit    = 8'd255;
        bus.load     = 1'b1;
        bus.load_val = 8'd254;
        cyc(1);
        bus.load = 1'b0;
        chk_all("free_load", 254, 0, 0, 0);
        cyc(1);
        chk_all("free_255", 255, 0, 0, 0);
        cyc(1);
        chk_all("free_wrap", 0, 1, 0, 0);
        cyc(1);
        chk_all("free_1", 1, 0, 0, 0);

        // WRAP down with limit 0: tc on every step from 0
        bus.limit = 8'd0;
        bus.dir   = 1'b0;
        cyc(1);
        chk_all("w0_dn1", 0, 0, 0, 0);
        cyc(1);
        chk_all("w0_dn2", 0, 1, 0, 0);
        cyc(1);
        chk_all("w0_dn3", 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_mode_counter.md
MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 Parameter WIDTH, default 8: count, limit and load width in bits (2..32).
REQ-002 Parameter PRESC_W, default 4: prescaler divide-field width in bits (1..16).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  count enable; low freezes counter and prescaler.
REQ-006 Port mode  input  2  00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved (behaves as WRAP).
REQ-007 Port dir  input  1  1 = count up, 0 = count down.
REQ-008 Port limit  input  WIDTH  upper bound; count range is 0..limit inclusive.
REQ-009 Port presc_div  input  PRESC_W  one step every presc_div+1 enabled cycles.
REQ-010 Port load  input  1  synchronous load strobe.
REQ-011 Port load_val  input  WIDTH  value loaded into count when load=1.
REQ-012 Port start  input  1  ONESHOT arm/re-arm strobe.
REQ-013 Port count  output  WIDTH  registered current count.
REQ-014 Port tc  output  1  registered single-cycle terminal-count pulse.
REQ-015 Port busy  output  1  high while the ONESHOT FSM is in RUN.
REQ-016 Port done  output  1  high while the ONESHOT FSM is in DONE.

Function
REQ-017 Prescaler: internal counter p increments when en=1; tick = en & (p==presc_div); on tick p returns to 0; presc_div=0 gives tick on every enabled cycle.
REQ-018 Step: on a clock edge with tick=1, count changes by +1 (dir=1) or -1 (dir=0); the new value is visible the cycle after the tick edge.
REQ-019 Priority per edge: rst > load > start > step.
REQ-020 load=1: count <= load_val, p <= 0, no step, no tc, FSM state unchanged.
REQ-021 WRAP up: step from count>=limit gives 0 with tc=1; WRAP down: step from 0 gives limit with tc=1.
REQ-022 SATURATE up: count holds at limit; tc=1 only on the step whose result equals limit; a count above limit steps to limit; down symmetrically holds at 0.
REQ-023 ONESHOT FSM states IDLE, RUN, DONE; FSM is forced to IDLE whenever mode is not ONESHOT.
REQ-024 IDLE + start: count <= 0 (dir=1) or limit (dir=0), p <= 0, go to RUN; steps are ignored in IDLE.
REQ-025 RUN: steps as SATURATE; the step reaching limit (up) or 0 (down) gives tc=1 and a transition to DONE.
REQ-026 DONE: count held, done=1; start re-arms exactly as from IDLE; start in RUN restarts the run.
REQ-027 tc is 0 in every cycle not named in REQ-021/022/025; never high on two consecutive cycles unless steps occur on consecutive cycles.
REQ-028 limit=0: WRAP produces tc on every step with count=0; ONESHOT reaches DONE on the first step.
REQ-029 Changes to limit, dir, mode or presc_div take effect on the next edge; p>presc_div after a presc_div decrease wraps p to 0 without a tick.
REQ-030 All arithmetic is modulo 2^WIDTH unsigned; no output is ever X after reset.

Reset
REQ-031 rst=1 at an edge: count=0, p=0, FSM=IDLE, tc=0, busy=0, done=0 on the following cycle, regardless of every other input.
REQ-032 rst asserted mid-run aborts the run with no tc pulse.

Structure
REQ-033 A shared package holds the mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state type/encoding.
REQ-034 The prescaler is a separate sub-module, counter_prescaler (parameter PRESC_W; ports clk, rst, en, clr, div, tick).
REQ-035 The top module remains drop-in compatible with the existing 8-bit counter at defaults: WRAP, dir=1, limit=255, presc_div=0, en=1 reproduce a free-running counter.

Verification
REQ-036 WRAP, up, limit=5, presc_div=0, en=1 for 14 cycles -> count 0,1,2,3,4,5,0,1,...; tc high exactly on the two cycles count shows 0 after 5.
REQ-037 SATURATE, down, load_val=3, presc_div=2 -> count 3,2,1,0 changing every 3rd cycle then holds 0; one tc pulse with count=0.
REQ-038 ONESHOT, up, limit=4, start pulse -> busy for 4 steps, tc+done when count=4, count held at 4; second start -> count 0, busy again.
REQ-039 Simultaneous load=1 (load_val=9) and start=1 in IDLE -> count=9, FSM stays IDLE, tc=0.
REQ-040 rst pulsed during ONESHOT RUN at count=2 -> next cycle count=0, busy=0, done=0, no tc.
REQ-041 en=0 for 5 cycles mid-WRAP at count=7, presc_div=3 -> count and prescaler phase unchanged; counting resumes with the same phase.
